vec_addr_gen: RTL

Parametrised DRAM address generator for vector/burst memory instructions. On a start request it computes a base address from a register base plus a sign-extended immediate offset. It then emits a sequence of strided addresses, one per accepted beat, with downstream stall support. A PC load path forces the DRAM address bus to the fetch address and aborts any running sequence. It sits between the decode/control unit and the DRAM address port.

---
 rtl/vec_addr_gen.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/vec_addr_gen.sv
// vec_addr_gen: strided DRAM address generator for vector/burst memory ops.
// A start in IDLE loads addrBase + sext(imm_offset) and emits count+1 beats,
// advancing by the latched stride on each accepted (non-stalled) beat.
// setPC overrides everything: addr takes PC and any running sequence aborts.
// Build option: define VEC_ADDR_GEN_STRIDE_EN to use the signed stride port;
// when undefined the stride port is ignored and the increment is fixed at +1.

module vec_addr_gen #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned OFF_W  = 6,
   parameter int unsigned INC_W  = 4,
   parameter int unsigned CNT_W  = 4
) (
   input  logic              Clk1,
   input  logic              Rst_n,
   input  logic              setPC,
   input  logic [ADDR_W-1:0] PC,
   input  logic              start,
   input  logic [ADDR_W-1:0] addrBase,
   input  logic [OFF_W-1:0]  imm_offset,
   input  logic [INC_W-1:0]  stride,
   input  logic [CNT_W-1:0]  count,
   input  logic              stall,
   output logic [ADDR_W-1:0] addr,
   output logic              addr_valid,
   output logic              busy,
   output logic              done
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic              addr_valid_q, addr_valid_d;
   logic              done_q, done_d;

   logic [ADDR_W-1:0] off_ext;
   logic [ADDR_W-1:0] inc_ext;
   logic              beat_acc;

   assign off_ext = {{(ADDR_W-OFF_W){imm_offset[OFF_W-1]}}, imm_offset};

`ifdef VEC_ADDR_GEN_STRIDE_EN
   logic [INC_W-1:0] stride_q, stride_d;

   assign inc_ext = {{(ADDR_W-INC_W){stride_q[INC_W-1]}}, stride_q};
`else
   // Port kept for a stable instantiation footprint; its value is unused.
   logic unused_stride;

   assign unused_stride = ^stride;
   assign inc_ext       = ADDR_W'(1);
`endif

   // A beat leaves the block only while running, presented and not stalled.
   assign beat_acc = (state_q == RUN) && addr_valid_q && !stall;

   // Next-state logic: setPC first, then the IDLE/RUN sequencing.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      remaining_d  = remaining_q;
      addr_valid_d = addr_valid_q;
      done_d       = 1'b0;
`ifdef VEC_ADDR_GEN_STRIDE_EN
      stride_d     = stride_q;
`endif
      if (setPC) begin
         // Abort: a simultaneous start is dropped, no done pulse.
         addr_d       = PC;
         state_d      = IDLE;
         addr_valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               addr_valid_d = 1'b0;
               if (start) begin
                  addr_d       = addrBase + off_ext;
                  remaining_d  = count;
                  state_d      = RUN;
                  addr_valid_d = 1'b1;
`ifdef VEC_ADDR_GEN_STRIDE_EN
                  stride_d     = stride;
`endif
               end
            end
            RUN: begin
               if (beat_acc) begin
                  if (remaining_q != '0) begin
                     addr_d      = addr_q + inc_ext;
                     remaining_d = remaining_q - CNT_W'(1);
                  end else begin
                     // Last beat: addr keeps the final address.
                     state_d      = IDLE;
                     addr_valid_d = 1'b0;
                     done_d       = 1'b1;
                  end
               end
            end
            default: begin
               state_d      = IDLE;
               addr_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge Clk1 or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         remaining_q  <= '0;
         addr_valid_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         remaining_q  <= remaining_d;
         addr_valid_q <= addr_valid_d;
         done_q       <= done_d;
      end
   end

`ifdef VEC_ADDR_GEN_STRIDE_EN
   // Latched stride, captured with start.
   always_ff @(posedge Clk1 or negedge Rst_n) begin
      if (!Rst_n) begin
         stride_q <= '0;
      end else begin
         stride_q <= stride_d;
      end
   end
`endif

   assign addr       = addr_q;
   assign addr_valid = addr_valid_q;
   assign busy       = (state_q == RUN);
   assign done       = done_q;

endmodule
